// File: rtl/grf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : grf_write_arbiter_pkg
// Brief  : Shared register-file write-back definitions used by the W-stage,
//          the GRF write arbiter and the hazard unit.
// Rev    : 1.0  initial release
// ============================================================================
package grf_write_arbiter_pkg;

  localparam int CPU_ADDR_W = 5;
  localparam int CPU_DATA_W = 32;
  // Register index that reads as zero and silently drops writes
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic                  we;
    logic [CPU_ADDR_W-1:0] waddr;
    logic [CPU_DATA_W-1:0] wdata;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/grf_write_arbiter_wb_kill_queue.sv
`default_nettype none
// ============================================================================
// Module : wb_kill_queue
// Brief  : Circular FIFO of pending MDU results. Each entry carries a live bit
//          that a younger pipeline write to the same register clears. Dead
//          head entries retire on their own; the next live entry is offered.
// Rev    : 1.0  initial release
// ============================================================================
module wb_kill_queue
  import grf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int QDEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq,
  input  logic [ADDR_W-1:0]    enq_addr,
  input  logic [DATA_W-1:0]    enq_data,
  input  logic                 kill,
  input  logic [ADDR_W-1:0]    kill_addr,
  input  logic                 pop,
  output logic                 ready,
  output logic                 out_live,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [DATA_W-1:0]    out_data,
  output logic [2**ADDR_W-1:0] live_mask
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int NREG  = 2**ADDR_W;

  logic [ADDR_W-1:0] r_addr [QDEPTH];
  logic [DATA_W-1:0] r_data [QDEPTH];
  logic [QDEPTH-1:0] r_live;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_ready;
  logic [NREG-1:0]   r_mask;

  logic              w_push;
  logic              w_dead;
  logic              w_take;
  logic [PTR_W-1:0]  w_head_nx;
  logic [PTR_W-1:0]  w_sel;
  logic [PTR_W-1:0]  w_head_next;
  logic [1:0]        w_npop;
  logic [CNT_W-1:0]  w_count_next;
  logic [QDEPTH-1:0] w_live_next;
  logic [NREG-1:0]   w_mask_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Head selection: a dead head retires for free, letting the entry behind it be offered
  always_comb begin
    w_push      = enq && r_ready;
    w_head_nx   = ptr_inc(r_head);
    w_dead      = (r_count != '0) && !r_live[r_head];
    w_sel       = w_dead ? w_head_nx : r_head;
    out_live    = w_dead ? ((r_count > CNT_W'(1)) && r_live[w_head_nx])
                         : ((r_count != '0) && r_live[r_head]);
    w_take      = pop && out_live;
    w_npop      = {1'b0, w_dead} + {1'b0, w_take};
    w_head_next = w_take ? ptr_inc(w_sel) : (w_dead ? w_head_nx : r_head);
    w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_npop);
  end

  // Next live bits and the register mask they imply; the new entry is younger than any kill
  always_comb begin
    w_live_next = r_live;
    w_mask_next = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (kill && (r_addr[i] == kill_addr)) w_live_next[i] = 1'b0;
      if (w_take && (w_sel == PTR_W'(i)))  w_live_next[i] = 1'b0;
      if (w_push && (r_tail == PTR_W'(i))) begin
        w_live_next[i] = 1'b1;
        w_mask_next[enq_addr] = 1'b1;
      end else if (w_live_next[i]) begin
        w_mask_next[r_addr[i]] = 1'b1;
      end
    end
    w_mask_next[0] = 1'b0;
  end

  // Queue control state; ready is conservative and registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_live  <= '0;
      r_ready <= 1'b0;
      r_mask  <= '0;
    end else begin
      r_head  <= w_head_next;
      if (w_push) r_tail <= ptr_inc(r_tail);
      r_count <= w_count_next;
      r_live  <= w_live_next;
      r_ready <= (w_count_next < CNT_W'(QDEPTH));
      r_mask  <= w_mask_next;
    end
  end

  // Entry payload storage; only meaningful while the entry is occupied
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= enq_addr;
      r_data[r_tail] <= enq_data;
    end
  end

  assign ready     = r_ready;
  assign out_addr  = r_addr[w_sel];
  assign out_data  = r_data[w_sel];
  assign live_mask = r_mask;

endmodule
`default_nettype wire

// File: rtl/grf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : grf_write_arbiter
// Brief  : Sole driver of the GRF write port. The pipeline W-stage always wins;
//          MDU results wait in a kill-able queue and drain on idle cycles.
// Rev    : 1.0  initial release
// ============================================================================
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int QDEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_we,
  input  logic [ADDR_W-1:0]    pipe_waddr,
  input  logic [DATA_W-1:0]    pipe_wdata,
  input  logic                 mdu_valid,
  output logic                 mdu_ready,
  input  logic [ADDR_W-1:0]    mdu_waddr,
  input  logic [DATA_W-1:0]    mdu_wdata,
  output logic                 grf_wenable,
  output logic [ADDR_W-1:0]    grf_waddr,
  output logic [DATA_W-1:0]    grf_wdata,
  output logic [2**ADDR_W-1:0] busy_mask
);

  logic              w_pipe_hit;
  logic              w_mdu_enq;
  logic              w_q_live;
  logic [ADDR_W-1:0] w_q_addr;
  logic [DATA_W-1:0] w_q_data;

  // Writes to the zero register are treated as no request at all
  assign w_pipe_hit = pipe_we   && (pipe_waddr != ADDR_W'(REG_ZERO));
  assign w_mdu_enq  = mdu_valid && (mdu_waddr  != ADDR_W'(REG_ZERO));

  wb_kill_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .enq       (w_mdu_enq),
    .enq_addr  (mdu_waddr),
    .enq_data  (mdu_wdata),
    .kill      (w_pipe_hit),
    .kill_addr (pipe_waddr),
    .pop       (!w_pipe_hit),
    .ready     (mdu_ready),
    .out_live  (w_q_live),
    .out_addr  (w_q_addr),
    .out_data  (w_q_data),
    .live_mask (busy_mask)
  );

  // Registered port select: pipeline first, then a live queued result, else idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_wenable <= 1'b0;
      grf_waddr   <= '0;
      grf_wdata   <= '0;
    end else if (w_pipe_hit) begin
      grf_wenable <= 1'b1;
      grf_waddr   <= pipe_waddr;
      grf_wdata   <= pipe_wdata;
    end else if (w_q_live) begin
      grf_wenable <= 1'b1;
      grf_waddr   <= w_q_addr;
      grf_wdata   <= w_q_data;
    end else begin
      grf_wenable <= 1'b0;
      grf_waddr   <= '0;
      grf_wdata   <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_grf_write_arbiter
// Brief  : Directed scoreboard bench for grf_write_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_grf_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int QDEPTH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_waddr;
  logic [DATA_W-1:0] mdu_wdata;
  logic              grf_wenable;
  logic [ADDR_W-1:0] grf_waddr;
  logic [DATA_W-1:0] grf_wdata;
  logic [31:0]       busy_mask;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  grf_write_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .QDEPTH (QDEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_we     (pipe_we),
    .pipe_waddr  (pipe_waddr),
    .pipe_wdata  (pipe_wdata),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_waddr   (mdu_waddr),
    .mdu_wdata   (mdu_wdata),
    .grf_wenable (grf_wenable),
    .grf_waddr   (grf_waddr),
    .grf_wdata   (grf_wdata),
    .busy_mask   (busy_mask)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic pwe, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                       input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
    pipe_we    = pwe;
    pipe_waddr = pa;
    pipe_wdata = pd;
    mdu_valid  = mv;
    mdu_waddr  = ma;
    mdu_wdata  = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write presented on the port must be the next expected one
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && grf_wenable === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL port_write: got $%0d=0x%0h expected no write", grf_waddr, grf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (grf_waddr !== e.a || grf_wdata !== e.d) begin
          miscompares++;
          $display("FAIL port_write: got $%0d=0x%0h expected $%0d=0x%0h",
                   grf_waddr, grf_wdata, e.a, e.d);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("rst_wenable", 32'(grf_wenable), 0);
    check("rst_waddr",   32'(grf_waddr),   0);
    check("rst_wdata",   grf_wdata,        0);
    check("rst_busy",    busy_mask,        0);
    check("rst_ready",   32'(mdu_ready),   0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();
    check("ready_after_release", 32'(mdu_ready), 1);

    // Pipeline priority: MDU result held while the pipe owns the port
    drive(1, 8, 32'h11, 1, 9, 32'hAA); expect_wr(8, 32'h11); step();
    check("prio_busy9", busy_mask, 32'h200);
    drive(1, 8, 32'h11, 0, 0, 0);      expect_wr(8, 32'h11); step();
    check("prio_busy9_held", busy_mask, 32'h200);
    drive(0, 0, 0, 0, 0, 0);           expect_wr(9, 32'hAA); step();
    check("prio_busy_clear", busy_mask, 0);
    step();
    check("prio_idle", 32'(grf_wenable), 0);

    // Kill: younger pipe write to $5 supersedes queued MDU result
    drive(1, 3, 32'h33, 1, 5, 32'h1);  expect_wr(3, 32'h33); step();
    check("kill_busy5", busy_mask, 32'h20);
    drive(1, 5, 32'h2, 0, 0, 0);       expect_wr(5, 32'h2);  step();
    check("kill_busy_clear", busy_mask, 0);
    drive(0, 0, 0, 0, 0, 0); step();
    check("kill_no_emit", 32'(grf_wenable), 0);
    check("kill_ready", 32'(mdu_ready), 1);

    // Dead head and live next head retire in the same cycle
    drive(1, 1, 32'h1, 1, 5, 32'h50);  expect_wr(1, 32'h1);  step();
    drive(1, 1, 32'h2, 1, 6, 32'h60);  expect_wr(1, 32'h2);  step();
    check("dh_ready_full", 32'(mdu_ready), 0);
    check("dh_busy56", busy_mask, 32'h60);
    drive(1, 5, 32'h55, 0, 0, 0);      expect_wr(5, 32'h55); step();
    check("dh_busy6", busy_mask, 32'h40);
    drive(0, 0, 0, 0, 0, 0);           expect_wr(6, 32'h60); step();
    check("dh_busy_clear", busy_mask, 0);
    check("dh_ready", 32'(mdu_ready), 1);
    step();
    check("dh_idle", 32'(grf_wenable), 0);

    // Simultaneous kill and enqueue to the same register: new entry stays live
    drive(1, 4, 32'h40, 1, 4, 32'h44); expect_wr(4, 32'h40); step();
    check("ek_busy4", busy_mask, 32'h10);
    drive(0, 0, 0, 0, 0, 0);           expect_wr(4, 32'h44); step();
    check("ek_busy_clear", busy_mask, 0);

    // Full queue: mdu_valid held, nothing lost, order kept
    drive(1, 1, 32'h101, 1, 10, 32'hA0); expect_wr(1, 32'h101); step();
    check("full_ready1", 32'(mdu_ready), 1);
    drive(1, 1, 32'h102, 1, 11, 32'hB0); expect_wr(1, 32'h102); step();
    check("full_ready0", 32'(mdu_ready), 0);
    check("full_busy", busy_mask, 32'hC00);
    drive(1, 1, 32'h103, 1, 12, 32'hC0); expect_wr(1, 32'h103); step();
    check("full_ready_held", 32'(mdu_ready), 0);
    drive(0, 0, 0, 1, 12, 32'hC0);       expect_wr(10, 32'hA0); step();
    check("full_ready_back", 32'(mdu_ready), 1);
    expect_wr(11, 32'hB0); step();
    check("full_busy12", busy_mask, 32'h1000);
    drive(0, 0, 0, 0, 0, 0);             expect_wr(12, 32'hC0); step();
    check("full_busy_clear", busy_mask, 0);
    step();
    check("full_idle", 32'(grf_wenable), 0);

    // Zero register on both sides
    drive(1, 2, 32'h22, 1, 7, 32'h77);     expect_wr(2, 32'h22); step();
    drive(1, 0, 32'hDEAD, 1, 0, 32'h55);   expect_wr(7, 32'h77); step();
    check("zero_busy", busy_mask, 0);
    drive(1, 0, 32'hDEAD, 0, 0, 0); step();
    check("zero_wenable", 32'(grf_wenable), 0);
    check("zero_waddr",   32'(grf_waddr),   0);
    check("zero_wdata",   grf_wdata,        0);
    drive(0, 0, 0, 0, 0, 0); step();
    check("zero_idle", 32'(grf_wenable), 0);

    // Reset mid-traffic with two queued entries
    drive(1, 1, 32'h201, 1, 13, 32'hD0); expect_wr(1, 32'h201); step();
    drive(1, 1, 32'h202, 1, 14, 32'hE0); expect_wr(1, 32'h202); step();
    check("mrst_busy", busy_mask, 32'h6000);
    @(negedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    check("mrst_wenable", 32'(grf_wenable), 0);
    check("mrst_waddr",   32'(grf_waddr),   0);
    check("mrst_wdata",   grf_wdata,        0);
    check("mrst_busy0",   busy_mask,        0);
    check("mrst_ready",   32'(mdu_ready),   0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();
    check("mrst_ready_back", 32'(mdu_ready), 1);
    check("mrst_busy_after", busy_mask, 0);
    step();
    check("mrst_flushed", 32'(grf_wenable), 0);

    step();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
